// File: rtl/connect4_pkg.sv
// Shared Connect-4 types and board-size defaults for the move controller slice.
package connect4_pkg;

    localparam int unsigned DEFAULT_COLS = 7;
    localparam int unsigned DEFAULT_ROWS = 6;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    // Kept as plain constants so the encoding matches the legacy state register
    typedef logic [1:0] mc_state_t;
    localparam mc_state_t IDLE = 2'd0;
    localparam mc_state_t REQ  = 2'd1;
    localparam mc_state_t DONE = 2'd2;

    function automatic player_t other_player(input player_t p);
        return (p == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/move_controller_col_height_table.sv
// Per-column fill height counters (saturating at ROWS) with a read port and
// an all-columns-full flag.
module col_height_table
    import connect4_pkg::*;
#(
    parameter int unsigned COLS = DEFAULT_COLS,
    parameter int unsigned ROWS = DEFAULT_ROWS,
    localparam int unsigned COL_W = $clog2(COLS),
    localparam int unsigned ROW_W = $clog2(ROWS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic [COL_W-1:0] inc_col,
    input  logic [COL_W-1:0] rd_col,
    output logic [ROW_W-1:0] rd_height,
    output logic             all_full
);

    logic [ROW_W-1:0] height_q [COLS];
    logic [ROW_W-1:0] height_d [COLS];

    // Next heights: bump the selected column unless it is already full
    always_comb begin
        for (int unsigned i = 0; i < COLS; i++) begin
            height_d[i] = height_q[i];
            if (inc_en && (inc_col == COL_W'(i)) && (height_q[i] != ROW_W'(ROWS))) begin
                height_d[i] = height_q[i] + ROW_W'(1);
            end
        end
    end

    // Full-board detection across every column
    always_comb begin
        all_full = 1'b1;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (height_q[i] != ROW_W'(ROWS)) begin
                all_full = 1'b0;
            end
        end
    end

    assign rd_height = height_q[rd_col];

    // Height registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                height_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < COLS; i++) begin
                height_q[i] <= height_d[i];
            end
        end
    end

endmodule

// File: rtl/move_controller.sv
// Connect-4 move controller: cursor, player turn and req/ack board writes.
// Build option: define CURSOR_WRAP_EN to make the cursor wrap at the edges
// instead of saturating.
module move_controller
    import connect4_pkg::*;
#(
    parameter int unsigned COLS = DEFAULT_COLS,
    parameter int unsigned ROWS = DEFAULT_ROWS,
    localparam int unsigned COL_W = $clog2(COLS),
    localparam int unsigned ROW_W = $clog2(ROWS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left_pulse,
    input  logic             right_pulse,
    input  logic             put_pulse,
    input  logic             game_over,
    input  logic             wr_ack,
    output logic             wr_req,
    output logic [COL_W-1:0] wr_col,
    output logic [ROW_W-1:0] wr_row,
    output logic             wr_player,
    output logic [COL_W-1:0] cursor_col,
    output logic             player,
    output logic             move_done,
    output logic             col_full_err,
    output logic             board_full
);

    mc_state_t        state_q, state_d;
    logic [COL_W-1:0] cursor_q, cursor_d;
    player_t          player_q, player_d;
    logic             wr_req_q, wr_req_d;
    logic [COL_W-1:0] wr_col_q, wr_col_d;
    logic [ROW_W-1:0] wr_row_q, wr_row_d;
    player_t          wr_player_q, wr_player_d;
    logic             move_done_q, move_done_d;
    logic             col_full_err_q, col_full_err_d;

    logic             inc_en;
    logic [ROW_W-1:0] cur_height;

    col_height_table #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_heights (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (inc_en),
        .inc_col   (wr_col_q),
        .rd_col    (cursor_q),
        .rd_height (cur_height),
        .all_full  (board_full)
    );

    // FSM, cursor movement and write-request latching
    always_comb begin
        state_d        = state_q;
        cursor_d       = cursor_q;
        player_d       = player_q;
        wr_req_d       = wr_req_q;
        wr_col_d       = wr_col_q;
        wr_row_d       = wr_row_q;
        wr_player_d    = wr_player_q;
        move_done_d    = 1'b0;
        col_full_err_d = 1'b0;
        inc_en         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!game_over) begin
                    if (put_pulse) begin
                        if (cur_height < ROW_W'(ROWS)) begin
                            wr_col_d    = cursor_q;
                            wr_row_d    = cur_height;
                            wr_player_d = player_q;
                            wr_req_d    = 1'b1;
                            state_d     = REQ;
                        end else begin
                            col_full_err_d = 1'b1;
                        end
                    end else if (left_pulse) begin
`ifdef CURSOR_WRAP_EN
                        if (cursor_q == '0) begin
                            cursor_d = COL_W'(COLS - 1);
                        end else begin
                            cursor_d = cursor_q - COL_W'(1);
                        end
`else
                        if (cursor_q != '0) begin
                            cursor_d = cursor_q - COL_W'(1);
                        end
`endif
                    end else if (right_pulse) begin
`ifdef CURSOR_WRAP_EN
                        if (cursor_q == COL_W'(COLS - 1)) begin
                            cursor_d = '0;
                        end else begin
                            cursor_d = cursor_q + COL_W'(1);
                        end
`else
                        if (cursor_q != COL_W'(COLS - 1)) begin
                            cursor_d = cursor_q + COL_W'(1);
                        end
`endif
                    end
                end
            end
            REQ: begin
                // move_done is registered here so it is high exactly while in DONE
                if (wr_ack) begin
                    wr_req_d    = 1'b0;
                    move_done_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                inc_en   = 1'b1;
                player_d = other_player(player_q);
                state_d  = IDLE;
            end
            default: begin
                wr_req_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cursor_q       <= COL_W'(COLS / 2);
            player_q       <= P1;
            wr_req_q       <= 1'b0;
            wr_col_q       <= '0;
            wr_row_q       <= '0;
            wr_player_q    <= P1;
            move_done_q    <= 1'b0;
            col_full_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cursor_q       <= cursor_d;
            player_q       <= player_d;
            wr_req_q       <= wr_req_d;
            wr_col_q       <= wr_col_d;
            wr_row_q       <= wr_row_d;
            wr_player_q    <= wr_player_d;
            move_done_q    <= move_done_d;
            col_full_err_q <= col_full_err_d;
        end
    end

    assign wr_req       = wr_req_q;
    assign wr_col       = wr_col_q;
    assign wr_row       = wr_row_q;
    assign wr_player    = wr_player_q;
    assign cursor_col   = cursor_q;
    assign player       = player_q;
    assign move_done    = move_done_q;
    assign col_full_err = col_full_err_q;

endmodule
